control_seq: RTL and testbench

//  Multi-cycle, parametrised successor to the combinational control decoder.

---
 rtl/control_seq_if.sv | 41 ++++
 rtl/control_seq.sv | 172 +++++++++++++++++
 tb/tb_control_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/control_seq_if.sv
// Bundle of the sequencer's fetch, ALU-flag, data-memory and regfile-control
// signals. The master side drives instructions, flags and mem_ack; the
// slave side (the sequencer) returns requests and strobes.
interface control_seq_if #(
   parameter int REG_IDX_W = 4
) ();
   localparam int INST_W = REG_IDX_W + 5;

   logic                 inst_valid;
   logic [INST_W-1:0]    inst;
   logic                 inst_req;
   logic                 z;
   logic                 c;
   logic                 n;
   logic                 v;
   logic                 mem_ack;
   logic                 memory_read_en;
   logic                 memory_write_en;
   logic                 reg_write_en;
   logic [REG_IDX_W-1:0] reg_write_number;
   logic [REG_IDX_W-1:0] reg_from_number;
   logic                 reg_to_reg;
   logic                 fetch_acc_en;
   logic                 branch_en;
   logic [3:0]           flags_q;
   logic                 mem_err;

   modport master (
      output inst_valid, inst, z, c, n, v, mem_ack,
      input  inst_req, memory_read_en, memory_write_en, reg_write_en,
             reg_write_number, reg_from_number, reg_to_reg, fetch_acc_en,
             branch_en, flags_q, mem_err
   );

   modport slave (
      input  inst_valid, inst, z, c, n, v, mem_ack,
      output inst_req, memory_read_en, memory_write_en, reg_write_en,
             reg_write_number, reg_from_number, reg_to_reg, fetch_acc_en,
             branch_en, flags_q, mem_err
   );
endinterface

// File: rtl/control_seq.sv
// Multi-cycle control sequencer: FETCH -> EXEC -> (MEM) -> FETCH.
// Latches one instruction per pass, decodes one-cycle strobes in EXEC,
// keeps a flag register for branches and bounds data-memory waits.
// Outputs are decoded from registered state only (plus mem_ack in MEM so a
// load can write back in the very cycle the memory answers).
module control_seq #(
   parameter int REG_IDX_W   = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input logic          clk,
   input logic          rst_n,
   control_seq_if.slave bus
);
   localparam int INST_W = REG_IDX_W + 5;
   localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      MEM   = 2'd2
   } state_t;

   state_t               state_r, state_nxt_s;
   logic [INST_W-1:0]    inst_r, inst_nxt_s;
   logic [3:0]           flags_r, flags_nxt_s;
   logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;

   logic                 cls_s;
   logic [2:0]           sub_s;
   logic [3:0]           op_s;
   logic [REG_IDX_W-1:0] r_s;
   logic                 is_load_s;
   logic [3:0]           flags_in_s;
   logic                 f_z_s, f_c_s, f_n_s, f_v_s;

   logic                 inst_req_s, rd_s, wr_s, we_s, r2r_s, acc_s, br_s, err_s;
   logic [REG_IDX_W-1:0] wnum_s, fnum_s;

   // Instruction fields and flag aliases.
   assign cls_s      = inst_r[INST_W-1];
   assign sub_s      = inst_r[INST_W-2:INST_W-4];
   assign op_s       = inst_r[INST_W-2:REG_IDX_W];
   assign r_s        = inst_r[REG_IDX_W-1:0];
   assign is_load_s  = (op_s == 4'b0000);
   assign flags_in_s = {bus.z, bus.c, bus.n, bus.v};
   assign f_z_s      = flags_r[3];
   assign f_c_s      = flags_r[2];
   assign f_n_s      = flags_r[1];
   assign f_v_s      = flags_r[0];

   // State, instruction latch, flag register and timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= FETCH;
         inst_r  <= {INST_W{1'b0}};
         flags_r <= 4'b0000;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         inst_r  <= inst_nxt_s;
         flags_r <= flags_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state, decode strobes and memory wait/timeout handling.
   always_comb begin
      state_nxt_s = state_r;
      inst_nxt_s  = inst_r;
      flags_nxt_s = flags_r;
      cnt_nxt_s   = cnt_r;
      inst_req_s  = 1'b0;
      rd_s        = 1'b0;
      wr_s        = 1'b0;
      we_s        = 1'b0;
      r2r_s       = 1'b0;
      acc_s       = 1'b0;
      br_s        = 1'b0;
      err_s       = 1'b0;
      wnum_s      = {REG_IDX_W{1'b0}};
      fnum_s      = {REG_IDX_W{1'b0}};
      case (state_r)
         FETCH: begin
            inst_req_s = 1'b1;
            if (bus.inst_valid) begin
               inst_nxt_s  = bus.inst;
               state_nxt_s = EXEC;
            end else begin
               state_nxt_s = FETCH;
            end
         end
         EXEC: begin
            state_nxt_s = FETCH;
            cnt_nxt_s   = {CNT_W{1'b0}};
            if (cls_s) begin
               // Branches test the flags held before this instruction.
               case (sub_s)
                  3'b000:  br_s = f_n_s & ~f_z_s;
                  3'b001:  br_s = ~f_n_s & ~f_z_s;
                  3'b010:  br_s = f_z_s;
                  3'b011:  br_s = 1'b1;
                  3'b100: begin
                     acc_s = 1'b1;
                     we_s  = 1'b1;
                  end
                  3'b101:  br_s = ~f_z_s;
                  3'b110:  br_s = f_c_s;
                  3'b111:  br_s = f_v_s;
                  default: br_s = 1'b0;
               endcase
            end else begin
               case (op_s)
                  4'b0000, 4'b0001: state_nxt_s = MEM;
                  4'b1010: begin
                     fnum_s      = r_s;
                     flags_nxt_s = flags_in_s;
                  end
                  4'b1100: begin
                     r2r_s  = 1'b1;
                     wnum_s = r_s;
                     we_s   = 1'b1;
                  end
                  4'b1101: begin
                     r2r_s  = 1'b1;
                     fnum_s = r_s;
                     we_s   = 1'b1;
                  end
                  default: begin
                     fnum_s      = r_s;
                     we_s        = 1'b1;
                     flags_nxt_s = flags_in_s;
                  end
               endcase
            end
         end
         MEM: begin
            rd_s   = is_load_s;
            wr_s   = ~is_load_s;
            fnum_s = r_s;
            // An ack in the last allowed cycle still completes normally.
            if (bus.mem_ack) begin
               we_s        = is_load_s;
               cnt_nxt_s   = {CNT_W{1'b0}};
               state_nxt_s = FETCH;
            end else if (cnt_r == TO_LAST_C) begin
               err_s       = 1'b1;
               cnt_nxt_s   = {CNT_W{1'b0}};
               state_nxt_s = FETCH;
            end else begin
               cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_nxt_s = FETCH;
            cnt_nxt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   assign bus.inst_req         = inst_req_s;
   assign bus.memory_read_en   = rd_s;
   assign bus.memory_write_en  = wr_s;
   assign bus.reg_write_en     = we_s;
   assign bus.reg_write_number = wnum_s;
   assign bus.reg_from_number  = fnum_s;
   assign bus.reg_to_reg       = r2r_s;
   assign bus.fetch_acc_en     = acc_s;
   assign bus.branch_en        = br_s;
   assign bus.flags_q          = flags_r;
   assign bus.mem_err          = err_s;
endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: a vector table for single-pass EXEC
// instructions plus hand-written LOAD/STORE, timeout and reset sequences.
module tb_control_seq;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   control_seq_if #(.REG_IDX_W(4)) bus ();

   control_seq #(.REG_IDX_W(4), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] inst;
      logic [3:0] fin;
      logic       we;
      logic [3:0] wn;
      logic [3:0] fn;
      logic       r2r;
      logic       acc;
      logic       br;
      logic [3:0] fq;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Present one instruction at a negedge; returns at the EXEC negedge.
   task automatic issue(input logic [8:0] ins, input logic [3:0] fl);
      @(negedge clk);
      bus.inst_valid = 1'b1;
      bus.inst       = ins;
      {bus.z, bus.c, bus.n, bus.v} = fl;
      @(negedge clk);
      bus.inst_valid = 1'b0;
   endtask

   initial begin
      int wcnt;
      int errs;
      int erridx;
      int bad;
      int rcnt;
      n_tests = 0;
      n_fail  = 0;
      //            inst     fin      we    wn    fn    r2r   acc   br    fq
      tbl[0]  = '{9'h0A7, 4'b0010, 1'b0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 4'b0010}; // CMP r7
      tbl[1]  = '{9'h100, 4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'b0010}; // BLT taken
      tbl[2]  = '{9'h120, 4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0010}; // BGT not
      tbl[3]  = '{9'h032, 4'b1000, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 4'b1000}; // ALU r2, z
      tbl[4]  = '{9'h140, 4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'b1000}; // BEQ taken
      tbl[5]  = '{9'h1A0, 4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1000}; // BNE z=1
      tbl[6]  = '{9'h0C3, 4'b0111, 1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'b1000}; // acc->r3
      tbl[7]  = '{9'h0D5, 4'b0111, 1'b1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 4'b1000}; // r5->acc
      tbl[8]  = '{9'h160, 4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'b1000}; // JMP
      tbl[9]  = '{9'h180, 4'b0000, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'b1000}; // ACC imm
      tbl[10] = '{9'h021, 4'b0100, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 4'b0100}; // ALU c
      tbl[11] = '{9'h1C0, 4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'b0100}; // BCS taken
      tbl[12] = '{9'h1E0, 4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0100}; // BVS not
      tbl[13] = '{9'h021, 4'b0001, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 4'b0001}; // ALU v
      tbl[14] = '{9'h1E0, 4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'b0001}; // BVS taken
      tbl[15] = '{9'h1A0, 4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'b0001}; // BNE z=0
      tbl[16] = '{9'h100, 4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0001}; // BLT not

      bus.inst_valid = 1'b0;
      bus.inst       = 9'h000;
      {bus.z, bus.c, bus.n, bus.v} = 4'b0000;
      bus.mem_ack    = 1'b0;
      rst_n          = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req", bus.inst_req, 1);
      chk("rst_outs", {bus.memory_read_en, bus.memory_write_en, bus.reg_write_en,
                       bus.reg_to_reg, bus.fetch_acc_en, bus.branch_en, bus.mem_err}, 0);
      chk("rst_flags", bus.flags_q, 0);
      rst_n = 1'b1;

      // Idle fetch: request stays up, stray inst ignored, then an ALU op.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.inst = 9'h0C3;
         chk("idle_req", bus.inst_req, 1);
         chk("idle_we", bus.reg_write_en, 0);
      end
      bus.inst_valid = 1'b1;
      bus.inst       = 9'h032;
      @(negedge clk);
      bus.inst_valid = 1'b0;
      chk("idle_exec_we", bus.reg_write_en, 1);
      chk("idle_exec_fn", bus.reg_from_number, 2);
      bus.inst = 9'h0C3;
      #1;
      chk("exec_ignores_inst", {bus.reg_to_reg, bus.reg_write_number}, 0);
      @(negedge clk);
      chk("exec_one_cycle", bus.reg_write_en, 0);
      chk("back_to_fetch", bus.inst_req, 1);

      // Table of single-pass instructions.
      for (int i = 0; i < 17; i++) begin
         issue(tbl[i].inst, tbl[i].fin);
         chk($sformatf("v%0d_req", i), bus.inst_req, 0);
         chk($sformatf("v%0d_we", i), bus.reg_write_en, tbl[i].we);
         chk($sformatf("v%0d_wn", i), bus.reg_write_number, tbl[i].wn);
         chk($sformatf("v%0d_fn", i), bus.reg_from_number, tbl[i].fn);
         chk($sformatf("v%0d_r2r", i), bus.reg_to_reg, tbl[i].r2r);
         chk($sformatf("v%0d_acc", i), bus.fetch_acc_en, tbl[i].acc);
         chk($sformatf("v%0d_br", i), bus.branch_en, tbl[i].br);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_flags", i), bus.flags_q, tbl[i].fq);
      end

      // LOAD r5 with ack on third MEM cycle.
      issue(9'h005, 4'b0000);
      chk("ld_exec", {bus.memory_read_en, bus.reg_write_en}, 0);
      rcnt = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k == 2) begin
            bus.mem_ack = 1'b1;
            #1;
            chk("ld_we_ack", bus.reg_write_en, 1);
            chk("ld_wn", bus.reg_write_number, 0);
         end else begin
            chk("ld_we_wait", bus.reg_write_en, 0);
         end
         chk("ld_fn", bus.reg_from_number, 5);
         chk("ld_wr", bus.memory_write_en, 0);
         if (bus.memory_read_en) rcnt++;
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("ld_rd_cycles", rcnt, 3);
      chk("ld_done", {bus.memory_read_en, bus.inst_req}, 1);

      // STORE with no ack: timeout.
      issue(9'h012, 4'b0000);
      wcnt = 0; errs = 0; erridx = 0; bad = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.memory_write_en) wcnt++;
         if (bus.mem_err) begin errs++; erridx = k; end
         if (bus.reg_write_en) bad++;
         if (!bus.memory_write_en) break;
      end
      chk("to_wr_cycles", wcnt, 15);
      chk("to_err_cycle", erridx, 15);
      chk("to_err_pulses", errs, 1);
      chk("to_no_write", bad, 0);
      chk("to_fetch", bus.inst_req, 1);

      // STORE with ack exactly in the timeout cycle: ack wins.
      issue(9'h013, 4'b0000);
      repeat (14) @(negedge clk);
      chk("ackto_pre_err", bus.mem_err, 0);
      @(negedge clk);
      bus.mem_ack = 1'b1;
      #1;
      chk("ackto_err", bus.mem_err, 0);
      chk("ackto_wr", bus.memory_write_en, 1);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("ackto_done", {bus.memory_write_en, bus.mem_err, bus.inst_req}, 1);

      // Asynchronous reset while a STORE is pending.
      chk("pre_rst_flags", bus.flags_q, 4'b0001);
      issue(9'h014, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      chk("mrst_wr_before", bus.memory_write_en, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_wr_async", bus.memory_write_en, 0);
      chk("mrst_req", bus.inst_req, 1);
      chk("mrst_flags", bus.flags_q, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_after", {bus.memory_write_en, bus.inst_req}, 1);
      chk("mrst_flags_after", bus.flags_q, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
